// File: rtl/rle_pkg.sv
// rtl/rle_pkg.sv - shared constants, FSM state type and helpers for the RLE stream scheduler
//
// Contents:
//   RUN_W_DEF     default run-length field width
//   TAG_S1..TAG_S3, TAG_EOF   two-bit source tags carried in out_data[RUN_W+1:RUN_W]
//   state_t       scheduler FSM states (RUN, FLUSH, EOF)
//   rr_next       round-robin successor over the three stream indices 0..2
//   tag_of        stream index -> output tag
package rle_pkg;

    localparam int RUN_W_DEF = 10;

    localparam logic [1:0] TAG_EOF = 2'b00;
    localparam logic [1:0] TAG_S1  = 2'b01;
    localparam logic [1:0] TAG_S2  = 2'b10;
    localparam logic [1:0] TAG_S3  = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_EOF   = 2'd2
    } state_t;

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    function automatic logic [1:0] tag_of(input logic [1:0] idx);
        case (idx)
            2'd0:    return TAG_S1;
            2'd1:    return TAG_S2;
            default: return TAG_S3;
        endcase
    endfunction

endpackage

// File: rtl/rle_sched_fifo.sv
// rtl/rle_sched_fifo.sv - synchronous per-stream FIFO with full/empty flags and occupancy count
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset (empties the FIFO)
//   wr_en, wr_data    write request; ignored while full (caller flags the drop)
//   rd_en, rd_data    pop request; rd_data always shows the head entry
//   full, empty       occupancy flags
//   count             entries held, 0..DEPTH
// A word written at an edge is only readable from the following cycle: there is
// no write-to-read bypass, which gives the scheduler its one-cycle minimum latency.
module rle_sched_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            // simultaneous push and pop leaves the occupancy unchanged
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rle_stream_scheduler.sv
// rtl/rle_stream_scheduler.sv - merges three RLE run streams into one tagged stream with end-of-frame markers
//
// Optional feature macro: RLE_SCHED_STATS_EN (adds frame_total / drop_total outputs).
//
// Ports:
//   CLK, RESET                 rising-edge clock, synchronous active-high reset
//   stream1..stream3, s_valid  run words per stream, s_valid[i-1] qualifies stream i
//   im_end                     end-of-image pulse; starts a flush ending in a marker
//   out_data, out_valid        {tag, run} output register, held while not accepted
//   out_ready                  consumer accepts out_data
//   busy                       high in FLUSH and EOF
//   ovf                        sticky per-stream overflow (word dropped on full FIFO)
//   frame_total, drop_total    (RLE_SCHED_STATS_EN only) markers emitted / words dropped
module rle_stream_scheduler
    import rle_pkg::*;
#(
    parameter int RUN_W      = RUN_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [RUN_W-1:0]   stream1,
    input  logic [RUN_W-1:0]   stream2,
    input  logic [RUN_W-1:0]   stream3,
    input  logic [2:0]         s_valid,
    input  logic               im_end,
    output logic [RUN_W+1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic [2:0]         ovf
`ifdef RLE_SCHED_STATS_EN
    ,
    output logic [15:0]        frame_total,
    output logic [15:0]        drop_total
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [RUN_W-1:0] wr_data [3];
    logic [RUN_W-1:0] rd_data [3];
    logic [CW-1:0]    count   [3];
    logic [2:0]       full;
    logic [2:0]       empty;
    logic [2:0]       rd_en;
    logic [2:0]       drop;

    state_t           state;
    logic [RUN_W-1:0] frame_cnt;
    logic             pending;
    logic [1:0]       last;

    logic [1:0]       c0, c1, c2, sel;
    logic [RUN_W-1:0] sel_run;
    logic             load_ok;
    logic             load_data;
    logic             all_empty;

    assign wr_data[0] = stream1;
    assign wr_data[1] = stream2;
    assign wr_data[2] = stream3;

    for (genvar i = 0; i < 3; i++) begin : g_fifo
        rle_sched_fifo #(
            .W     (RUN_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (CLK),
            .reset   (RESET),
            .wr_en   (s_valid[i]),
            .wr_data (wr_data[i]),
            .rd_en   (rd_en[i]),
            .rd_data (rd_data[i]),
            .full    (full[i]),
            .empty   (empty[i]),
            .count   (count[i])
        );
    end

    // Round-robin: candidates in order after the last granted stream.
    always_comb begin
        c0  = rr_next(last);
        c1  = rr_next(c0);
        c2  = rr_next(c1);
        sel = c2;
        if (!empty[c0]) begin
            sel = c0;
        end else if (!empty[c1]) begin
            sel = c1;
        end
        case (sel)
            2'd0:    sel_run = rd_data[0];
            2'd1:    sel_run = rd_data[1];
            default: sel_run = rd_data[2];
        endcase
    end

    // The out register can take a new word when empty or being consumed this cycle.
    assign load_ok   = !out_valid || out_ready;
    assign load_data = (state != ST_EOF) && load_ok && !(&empty);
    assign rd_en     = load_data ? (3'b001 << sel) : 3'b000;
    assign all_empty = ((count[0] | count[1] | count[2]) == '0);
    assign drop      = s_valid & full;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= ST_RUN;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            ovf       <= 3'b000;
            frame_cnt <= '0;
            pending   <= 1'b0;
            last      <= 2'd2;
        end else begin
            ovf <= ovf | drop;

            // EOF owns the out register for its single cycle; FLUSH only exits
            // once the register is free, so the marker never overwrites data.
            if (state == ST_EOF) begin
                out_data  <= {TAG_EOF, frame_cnt};
                out_valid <= 1'b1;
                frame_cnt <= '0;
            end else if (load_data) begin
                out_data  <= {tag_of(sel), sel_run};
                out_valid <= 1'b1;
                last      <= sel;
                if (frame_cnt != '1) begin
                    frame_cnt <= frame_cnt + RUN_W'(1);
                end
            end else if (load_ok) begin
                out_valid <= 1'b0;
            end

            case (state)
                ST_RUN: begin
                    if (im_end) begin
                        state <= ST_FLUSH;
                        busy  <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (im_end) begin
                        pending <= 1'b1;
                    end
                    if (all_empty && load_ok) begin
                        state <= ST_EOF;
                    end
                end
                ST_EOF: begin
                    // an im_end arriving in this very cycle also chains a new flush
                    if (pending || im_end) begin
                        state   <= ST_FLUSH;
                        pending <= 1'b0;
                    end else begin
                        state <= ST_RUN;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_RUN;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef RLE_SCHED_STATS_EN
    logic [16:0] drop_sum;

    always_comb begin
        drop_sum = {1'b0, drop_total} + 17'(drop[0]) + 17'(drop[1]) + 17'(drop[2]);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            frame_total <= '0;
            drop_total  <= '0;
        end else begin
            if (state == ST_EOF) begin
                frame_total <= frame_total + 16'd1;
            end
            drop_total <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_rle_stream_scheduler.sv
// tb/tb_rle_stream_scheduler.sv - self-checking bench for rle_stream_scheduler
module tb_rle_stream_scheduler;

    localparam int DEPTH = 4;

    logic        CLK;
    logic        RESET;
    logic [9:0]  stream1, stream2, stream3;
    logic [2:0]  s_valid;
    logic        im_end;
    logic [11:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic [2:0]  ovf;

    int total = 0;
    int bad   = 0;

    rle_stream_scheduler #(
        .RUN_W      (10),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .stream1   (stream1),
        .stream2   (stream2),
        .stream3   (stream3),
        .s_valid   (s_valid),
        .im_end    (im_end),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .ovf       (ovf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: per-stream queues, one output slot, frame word tally,
    // and a mode variable (0 running, 1 flushing, 2 emitting marker).
    logic [9:0]  q [3][$];
    logic        m_ov;
    logic [11:0] m_od;
    logic [2:0]  m_ovf;
    int          m_fc;
    int          m_mode;
    bit          m_pend;
    int          m_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input bit rst, input logic [2:0] sv, input logic [9:0] a,
                                  input logic [9:0] b, input logic [9:0] c, input bit ie, input bit rdy);
        int  sz [3];
        int  g;
        bit  ok;
        bit  none;
        logic [9:0] r [3];
        if (rst) begin
            for (int j = 0; j < 3; j++) q[j].delete();
            m_ov = 0; m_od = '0; m_ovf = '0; m_fc = 0; m_mode = 0; m_pend = 0; m_last = 2;
            return;
        end
        r[0] = a; r[1] = b; r[2] = c;
        for (int j = 0; j < 3; j++) sz[j] = q[j].size();
        ok   = !m_ov || rdy;
        none = (sz[0] == 0) && (sz[1] == 0) && (sz[2] == 0);
        if (m_mode == 2) begin
            m_od = {2'b00, 10'(m_fc)};
            m_ov = 1;
            m_fc = 0;
        end else begin
            g = -1;
            if (ok) begin
                for (int k = 1; k <= 3; k++) begin
                    if (g < 0 && sz[(m_last + k) % 3] > 0) g = (m_last + k) % 3;
                end
            end
            if (g >= 0) begin
                m_od = {2'(g + 1), q[g].pop_front()};
                m_ov = 1;
                m_last = g;
                if (m_fc < 1023) m_fc++;
            end else if (ok) begin
                m_ov = 0;
            end
        end
        for (int j = 0; j < 3; j++) begin
            if (sv[j]) begin
                if (sz[j] == DEPTH) m_ovf[j] = 1'b1;
                else q[j].push_back(r[j]);
            end
        end
        case (m_mode)
            0: if (ie) m_mode = 1;
            1: begin
                if (ie) m_pend = 1;
                if (none && ok) m_mode = 2;
            end
            default: begin
                if (m_pend || ie) begin m_mode = 1; m_pend = 0; end
                else m_mode = 0;
            end
        endcase
    endfunction

    task automatic step(input bit rst, input logic [2:0] sv, input logic [9:0] a, input logic [9:0] b,
                        input logic [9:0] c, input bit ie, input bit rdy);
        RESET = rst; s_valid = sv; stream1 = a; stream2 = b; stream3 = c; im_end = ie; out_ready = rdy;
        @(posedge CLK);
        model(rst, sv, a, b, c, ie, rdy);
        @(negedge CLK);
        chk("m_out_valid", 32'(out_valid), 32'(m_ov));
        chk("m_out_data", 32'(out_data), 32'(m_od));
        chk("m_busy", 32'(busy), 32'(m_mode != 0));
        chk("m_ovf", 32'(ovf), 32'(m_ovf));
    endtask

    task automatic idle(input bit rdy);
        step(0, 3'b000, 10'd0, 10'd0, 10'd0, 0, rdy);
    endtask

    task automatic do_reset();
        step(1, 3'b000, 10'd0, 10'd0, 10'd0, 0, 1);
    endtask

    logic        pv;
    logic [11:0] pd;
    int          exp_next;
    int          n_acc;
    bit          rdy_r;

    initial begin
        RESET = 1; s_valid = '0; stream1 = '0; stream2 = '0; stream3 = '0; im_end = 0; out_ready = 0;

        // reset state
        do_reset();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);

        // three streams in one cycle -> tags 01,10,11 back to back
        step(0, 3'b111, 10'd5, 10'd6, 10'd7, 0, 1);
        chk("rr_latency", 32'(out_valid), 32'd0);
        idle(1); chk("rr_s1", 32'(out_data), 32'h405);
        idle(1); chk("rr_s2", 32'(out_data), 32'h806);
        idle(1); chk("rr_s3", 32'(out_data), 32'hC07);
        idle(1); chk("rr_drained", 32'(out_valid), 32'd0);

        // stream2 fill with consumer stalled, then overflow
        for (int k = 1; k <= 5; k++) step(0, 3'b010, 10'd0, 10'(k), 10'd0, 0, 0);
        chk("fill_no_ovf", 32'(ovf), 32'd0);
        chk("fill_head", 32'(out_data), 32'h801);
        step(0, 3'b010, 10'd0, 10'd6, 10'd0, 0, 0);
        chk("fill_ovf", 32'(ovf), 32'b010);
        for (int k = 2; k <= 5; k++) begin
            idle(1);
            chk("fill_drain", 32'(out_data), 32'h800 + 32'(k));
        end
        idle(1); chk("fill_lost", 32'(out_valid), 32'd0);

        // three words then im_end -> marker with count 3
        do_reset();
        step(0, 3'b111, 10'd1, 10'd2, 10'd3, 0, 1);
        step(0, 3'b000, 10'd0, 10'd0, 10'd0, 1, 1);
        chk("flush_busy", 32'(busy), 32'd1);
        chk("flush_w1", 32'(out_data), 32'h401);
        idle(1); chk("flush_w2", 32'(out_data), 32'h802);
        idle(1); chk("flush_w3", 32'(out_data), 32'hC03);
        idle(1); chk("flush_gap", 32'(out_valid), 32'd0);
        idle(1);
        chk("eof_marker", 32'(out_data), 32'h003);
        chk("eof_valid", 32'(out_valid), 32'd1);
        chk("eof_busy", 32'(busy), 32'd0);

        // second im_end during flush -> chained second frame
        do_reset();
        step(0, 3'b001, 10'd4, 10'd0, 10'd0, 1, 1);
        step(0, 3'b011, 10'd5, 10'd6, 10'd0, 1, 1);
        chk("chain_w1", 32'(out_data), 32'h404);
        idle(1); chk("chain_w2", 32'(out_data), 32'h806);
        idle(1); chk("chain_w3", 32'(out_data), 32'h405);
        idle(1);
        step(0, 3'b001, 10'd7, 10'd0, 10'd0, 0, 1);
        chk("chain_mark1", 32'(out_data), 32'h003);
        chk("chain_busy", 32'(busy), 32'd1);
        step(0, 3'b010, 10'd0, 10'd8, 10'd0, 0, 1);
        chk("chain_w4", 32'(out_data), 32'h407);
        idle(1); chk("chain_w5", 32'(out_data), 32'h808);
        idle(1);
        idle(1);
        chk("chain_mark2", 32'(out_data), 32'h002);
        chk("chain_valid2", 32'(out_valid), 32'd1);
        chk("chain_idle", 32'(busy), 32'd0);

        // toggling consumer: hold while stalled, in-order, no loss
        do_reset();
        exp_next = 1;
        n_acc = 0;
        for (int i = 0; i < 20; i++) begin
            rdy_r = (i % 2 == 0);
            pv = out_valid;
            pd = out_data;
            if (pv && rdy_r) begin
                chk("tog_order", 32'(pd), 32'h400 + 32'(exp_next));
                exp_next++;
                n_acc++;
            end
            step(0, (i < 6) ? 3'b001 : 3'b000, 10'(i + 1), 10'd0, 10'd0, 0, rdy_r);
            if (pv && !rdy_r) chk("tog_hold", 32'(out_data), 32'(pd));
        end
        chk("tog_count", 32'(n_acc), 32'd6);
        chk("tog_no_ovf", 32'(ovf), 32'd0);

        // reset during flush with data buffered
        do_reset();
        step(0, 3'b111, 10'd1, 10'd2, 10'd3, 0, 0);
        step(0, 3'b000, 10'd0, 10'd0, 10'd0, 1, 0);
        step(0, 3'b111, 10'd9, 10'd9, 10'd9, 0, 0);
        step(0, 3'b111, 10'd9, 10'd9, 10'd9, 0, 0);
        step(0, 3'b111, 10'd9, 10'd9, 10'd9, 0, 0);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        do_reset();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ovf", 32'(ovf), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 5; k++) begin
            idle(1);
            chk("mid_rst_nomark", 32'(out_valid), 32'd0);
        end

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            logic [2:0] sv;
            sv[0] = ($urandom_range(0, 2) == 0);
            sv[1] = ($urandom_range(0, 2) == 0);
            sv[2] = ($urandom_range(0, 2) == 0);
            step(($urandom_range(0, 199) == 0), sv, 10'($urandom), 10'($urandom), 10'($urandom),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rle_stream_scheduler.md
RLE_STREAM_SCHEDULER -- requirements
Module: rle_stream_scheduler

Interface
REQ-001 Parameter RUN_W, default 10, SHALL set the run-length field width of every stream word.
REQ-002 Parameter FIFO_DEPTH, default 4 (power of two, >=2), SHALL set the entries per stream FIFO.
REQ-003 CLK  input  1  single clock; all logic on rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 stream1, stream2, stream3  input  RUN_W each  run-length words from the RLE encoder.
REQ-006 s_valid  input  3  bit i-1 qualifies stream i for one cycle.
REQ-007 im_end  input  1  one-cycle end-of-image pulse from the encoder.
REQ-008 out_data  output  RUN_W+2  {tag[1:0], run[RUN_W-1:0]} to the decoder/FIFO side.
REQ-009 out_valid  output  1  out_data valid; out_ready  input  1  consumer accepts.
REQ-010 busy  output  1  high while state is FLUSH or EOF.
REQ-011 ovf  output  3  sticky per-stream drop flags.

Function
REQ-012 Tags SHALL be: 01 stream1, 10 stream2, 11 stream3, 00 end-of-frame marker.
REQ-013 Each stream SHALL write into its own FIFO when its s_valid bit is high and the FIFO is not full; all three may be written in the same cycle.
REQ-014 A word presented to a full FIFO SHALL be dropped and the matching ovf bit set; ovf clears only on RESET.
REQ-015 Out register SHALL load when empty or when out_valid&&out_ready in the same cycle (no bubble on back-to-back transfers).
REQ-016 Source selection SHALL be round-robin over non-empty FIFOs, starting after the last granted stream; priority pointer advances only on a load.
REQ-017 out_data/out_valid SHALL be held stable while out_valid&&!out_ready.
REQ-018 Latency: a word written at edge t SHALL be visible on out_data after edge t+1 at the earliest; no FIFO write-to-read bypass.
REQ-019 FSM states: RUN, FLUSH, EOF; im_end in RUN SHALL move to FLUSH.
REQ-020 FLUSH SHALL continue accepting and draining words; when all FIFOs are empty and the out register is free or being consumed, move to EOF.
REQ-021 EOF SHALL load marker {00, frame_cnt} into the out register, clear frame_cnt, and return to RUN.
REQ-022 frame_cnt SHALL count data words loaded in the current frame, saturating at 2^RUN_W-1.
REQ-023 im_end while in FLUSH or EOF SHALL set one pending flag; on EOF exit with pending set, go directly to FLUSH and clear it; further im_end pulses are ignored.
REQ-024 FIFO write and read on the same entry in one cycle SHALL keep the occupancy count unchanged.

Reset
REQ-025 RESET SHALL empty all FIFOs, set out_valid=0, out_data=0, busy=0, ovf=0, frame_cnt=0, pending=0, state=RUN, and priority to stream1, with no words emitted in that cycle.
REQ-026 RESET mid-frame SHALL discard buffered words with no end-of-frame marker emitted.

Configuration
REQ-027 Macro RLE_SCHED_STATS_EN, when defined, SHALL add outputs frame_total[15:0] (markers emitted, wrapping) and drop_total[15:0] (dropped words, saturating), both cleared by RESET.
REQ-028 Without RLE_SCHED_STATS_EN, those ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Shared package rle_pkg SHALL hold RUN_W default, tag constants TAG_S1/TAG_S2/TAG_S3/TAG_EOF, and the FSM state enum.
REQ-030 Sub-module rle_sched_fifo (synchronous FIFO, full/empty, count) SHALL be instantiated three times.

Verification
REQ-031 s_valid=111 one cycle with runs 5,6,7, out_ready=1 -> tags 01,10,11 on consecutive cycles, runs 5,6,7.
REQ-032 Five writes to stream2 in 5 cycles with out_ready=0, FIFO_DEPTH=4 -> one word in the out register, four in the FIFO, no drop; a sixth write -> ovf=010, word lost.
REQ-033 Three data words, then im_end -> busy=1, three words drained, then marker out_data={00,3}, busy=0, state RUN.
REQ-034 im_end twice, second during FLUSH -> two markers, second carrying the count of words between them.
REQ-035 out_ready toggling 1,0,1 with steady input -> out_data unchanged while out_valid&&!out_ready, no word lost or duplicated.
REQ-036 RESET asserted in FLUSH with FIFOs non-empty -> next cycle out_valid=0, ovf=0, busy=0, no marker emitted.
